// File: rtl/byp_hazard_ctrl.sv
// ID-stage forwarding and load-use hazard controller: tracks the instructions in EX and DM,
// registers bypass selects into EX, and inserts one bubble per load-use hazard.
module byp_hazard_ctrl #(
    parameter int RADDR_W  = 4,
    parameter int ZERO_REG = 0,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RADDR_W-1:0] src0_addr_ID,
    input  logic [RADDR_W-1:0] src1_addr_ID,
    input  logic               re0_ID,
    input  logic               re1_ID,
    input  logic [RADDR_W-1:0] dst_addr_ID,
    input  logic               we_rf_ID,
    input  logic               ld_ID,
    input  logic               flush,
    input  logic               stall_ext,
    output logic               byp0_EX,
    output logic               byp1_EX,
    output logic               byp0_DM,
    output logic               byp1_DM,
    output logic               stall_IM_ID,
    output logic               stall_ID_EX,
    output logic               stall_EX_DM,
    output logic               bubble_ID_EX,
    output logic [CNT_W-1:0]   ldu_cnt
);

    localparam logic [RADDR_W-1:0] ZERO_ADDR = RADDR_W'(ZERO_REG);

    logic [RADDR_W-1:0] dst_ID_EX;
    logic               we_ID_EX;
    logic               ld_ID_EX;
    logic [RADDR_W-1:0] dst_EX_DM;
    logic               we_EX_DM;

    logic hit_ex0, hit_ex1, hit_dm0, hit_dm1;
    logic ldu;

    always_comb begin
        hit_ex0 = re0_ID & we_ID_EX & (src0_addr_ID == dst_ID_EX) & (src0_addr_ID != ZERO_ADDR);
        hit_ex1 = re1_ID & we_ID_EX & (src1_addr_ID == dst_ID_EX) & (src1_addr_ID != ZERO_ADDR);
        hit_dm0 = re0_ID & we_EX_DM & (src0_addr_ID == dst_EX_DM) & (src0_addr_ID != ZERO_ADDR);
        hit_dm1 = re1_ID & we_EX_DM & (src1_addr_ID == dst_EX_DM) & (src1_addr_ID != ZERO_ADDR);
        ldu     = ld_ID_EX & (hit_ex0 | hit_ex1);
    end

    // A flushed instruction is killed anyway, so a load-use on it must not hold the front end.
    always_comb begin
        stall_IM_ID  = stall_ext | (ldu & ~flush);
        stall_ID_EX  = stall_ext;
        stall_EX_DM  = stall_ext;
        bubble_ID_EX = ~stall_ext & (ldu | flush);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_ID_EX <= '0;
            we_ID_EX  <= 1'b0;
            ld_ID_EX  <= 1'b0;
            dst_EX_DM <= '0;
            we_EX_DM  <= 1'b0;
            byp0_EX   <= 1'b0;
            byp1_EX   <= 1'b0;
            byp0_DM   <= 1'b0;
            byp1_DM   <= 1'b0;
            ldu_cnt   <= '0;
        end else if (!stall_ext) begin
            dst_ID_EX <= dst_addr_ID;
            we_ID_EX  <= we_rf_ID & ~bubble_ID_EX;
            ld_ID_EX  <= ld_ID & ~bubble_ID_EX;
            dst_EX_DM <= dst_ID_EX;
            we_EX_DM  <= we_ID_EX;
            // EX result is younger than DM, so it wins when both match.
            byp0_EX   <= ~bubble_ID_EX & hit_ex0;
            byp1_EX   <= ~bubble_ID_EX & hit_ex1;
            byp0_DM   <= ~bubble_ID_EX & hit_dm0 & ~hit_ex0;
            byp1_DM   <= ~bubble_ID_EX & hit_dm1 & ~hit_ex1;
            if (ldu && !flush && (ldu_cnt != {CNT_W{1'b1}})) begin
                ldu_cnt <= ldu_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_byp_hazard_ctrl.sv
// Directed bench for byp_hazard_ctrl; a second instance with a 4-bit counter exercises saturation.
module tb_byp_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] src0_addr_ID, src1_addr_ID, dst_addr_ID;
    logic       re0_ID, re1_ID, we_rf_ID, ld_ID, flush, stall_ext;

    logic        byp0_EX, byp1_EX, byp0_DM, byp1_DM;
    logic        stall_IM_ID, stall_ID_EX, stall_EX_DM, bubble_ID_EX;
    logic [15:0] ldu_cnt;

    logic        s_byp0_EX, s_byp1_EX, s_byp0_DM, s_byp1_DM;
    logic        s_stall_IM_ID, s_stall_ID_EX, s_stall_EX_DM, s_bubble_ID_EX;
    logic [3:0]  s_ldu_cnt;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    byp_hazard_ctrl #(.RADDR_W(4), .ZERO_REG(0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .src0_addr_ID(src0_addr_ID), .src1_addr_ID(src1_addr_ID),
        .re0_ID(re0_ID), .re1_ID(re1_ID),
        .dst_addr_ID(dst_addr_ID), .we_rf_ID(we_rf_ID), .ld_ID(ld_ID),
        .flush(flush), .stall_ext(stall_ext),
        .byp0_EX(byp0_EX), .byp1_EX(byp1_EX), .byp0_DM(byp0_DM), .byp1_DM(byp1_DM),
        .stall_IM_ID(stall_IM_ID), .stall_ID_EX(stall_ID_EX), .stall_EX_DM(stall_EX_DM),
        .bubble_ID_EX(bubble_ID_EX), .ldu_cnt(ldu_cnt)
    );

    byp_hazard_ctrl #(.RADDR_W(4), .ZERO_REG(0), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .src0_addr_ID(src0_addr_ID), .src1_addr_ID(src1_addr_ID),
        .re0_ID(re0_ID), .re1_ID(re1_ID),
        .dst_addr_ID(dst_addr_ID), .we_rf_ID(we_rf_ID), .ld_ID(ld_ID),
        .flush(flush), .stall_ext(stall_ext),
        .byp0_EX(s_byp0_EX), .byp1_EX(s_byp1_EX), .byp0_DM(s_byp0_DM), .byp1_DM(s_byp1_DM),
        .stall_IM_ID(s_stall_IM_ID), .stall_ID_EX(s_stall_ID_EX), .stall_EX_DM(s_stall_EX_DM),
        .bubble_ID_EX(s_bubble_ID_EX), .ldu_cnt(s_ldu_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [3:0] s0, input logic r0, input logic [3:0] s1, input logic r1,
                          input logic [3:0] d, input logic we, input logic ld);
        src0_addr_ID = s0; re0_ID = r0;
        src1_addr_ID = s1; re1_ID = r1;
        dst_addr_ID  = d;  we_rf_ID = we; ld_ID = ld;
        #1;
    endtask

    task automatic check_byp(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, byp0_EX, byp1_EX, byp0_DM, byp1_DM}, {28'd0, exp});
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall_ext = 1'b0;
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        check_byp("reset_byp", 4'b0000);
        check("reset_cnt", 32'(ldu_cnt), 32'd0);
        check("reset_sat_cnt", 32'(s_ldu_cnt), 32'd0);
        check("reset_stalls", {29'd0, stall_IM_ID, stall_ID_EX, bubble_ID_EX}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back ALU dependency on r3
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
        tick();
        set_id(4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        check("b2b_no_stall", {30'd0, stall_IM_ID, bubble_ID_EX}, 32'd0);
        tick();
        check_byp("b2b_byp", 4'b1000);

        // Distance-2 dependency on r5, then both stages writing r5
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);
        tick();
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);
        tick();
        set_id(4'd0, 1'b0, 4'd5, 1'b1, 4'd5, 1'b1, 1'b0);
        tick();
        check_byp("dist2_byp_dm", 4'b0001);
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);
        tick();
        set_id(4'd0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0);
        tick();
        check_byp("dist2_ex_priority", 4'b0100);

        // Load-use on r7
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1);
        tick();
        set_id(4'd7, 1'b1, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0);
        check("ldu_stall", {29'd0, stall_IM_ID, bubble_ID_EX, stall_ID_EX}, 32'b110);
        check("ldu_cnt_before", 32'(ldu_cnt), 32'd0);
        tick();
        check("ldu_cnt_after", 32'(ldu_cnt), 32'd1);
        check_byp("ldu_bubble_byp", 4'b0000);
        check("ldu_released", {30'd0, stall_IM_ID, bubble_ID_EX}, 32'd0);
        tick();
        check_byp("ldu_byp_dm", 4'b0010);
        check("ldu_cnt_hold", 32'(ldu_cnt), 32'd1);

        // Zero register is never bypassed nor stalls, even from a load
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1);
        tick();
        set_id(4'd0, 1'b1, 4'd0, 1'b1, 4'd9, 1'b1, 1'b1);
        check("zero_no_stall", {30'd0, stall_IM_ID, bubble_ID_EX}, 32'd0);
        tick();
        check_byp("zero_byp", 4'b0000);
        // Matching addresses with re=0 must not hit
        set_id(4'd4, 1'b0, 4'd9, 1'b0, 4'd0, 1'b0, 1'b0);
        check("noread_no_stall", {30'd0, stall_IM_ID, bubble_ID_EX}, 32'd0);
        tick();
        check_byp("noread_byp", 4'b0000);

        // Flush while a load-use is present
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b1);
        tick();
        flush = 1'b1;
        set_id(4'd0, 1'b0, 4'd6, 1'b1, 4'd10, 1'b1, 1'b1);
        check("flush_ctrl", {30'd0, stall_IM_ID, bubble_ID_EX}, 32'b01);
        tick();
        flush = 1'b0;
        check("flush_cnt", 32'(ldu_cnt), 32'd1);
        check_byp("flush_byp", 4'b0000);
        set_id(4'd10, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        check("flush_ld_cleared", {30'd0, stall_IM_ID, bubble_ID_EX}, 32'd0);
        tick();
        check_byp("flush_we_cleared", 4'b0000);

        // External stall freezes a pending bypass and a pending load-use
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd11, 1'b1, 1'b0);
        tick();
        set_id(4'd11, 1'b1, 4'd0, 1'b0, 4'd12, 1'b1, 1'b1);
        tick();
        check_byp("stx_setup_byp", 4'b1000);
        stall_ext = 1'b1;
        set_id(4'd12, 1'b1, 4'd0, 1'b0, 4'd13, 1'b1, 1'b0);
        check("stx_ctrl", {28'd0, stall_IM_ID, stall_ID_EX, stall_EX_DM, bubble_ID_EX}, 32'b1110);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_byp("stx_frozen_byp", 4'b1000);
            check("stx_frozen_cnt", 32'(ldu_cnt), 32'd1);
        end
        stall_ext = 1'b0;
        #1;
        check("stx_release_ldu", {30'd0, stall_IM_ID, bubble_ID_EX}, 32'b11);
        tick();
        check("stx_release_cnt", 32'(ldu_cnt), 32'd2);
        check_byp("stx_release_byp", 4'b0000);

        // Reset asserted mid-bubble
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd14, 1'b1, 1'b1);
        tick();
        tick();
        set_id(4'd14, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        check("rst_pre_bubble", 32'(bubble_ID_EX), 32'd1);
        rst = 1'b1;
        #1;
        check_byp("rst_mid_byp", 4'b0000);
        check("rst_mid_cnt", 32'(ldu_cnt), 32'd0);
        check("rst_mid_sat_cnt", 32'(s_ldu_cnt), 32'd0);
        check("rst_mid_ctrl", {30'd0, stall_IM_ID, bubble_ID_EX}, 32'd0);
        rst = 1'b0;
        tick();
        check_byp("rst_post_byp", 4'b0000);

        // Drive 16 load-use hazards: the 4-bit counter saturates at F
        for (int i = 0; i < 16; i++) begin
            set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b1);
            tick();
            set_id(4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
            if (i == 15) check("sat_bubble", 32'(s_bubble_ID_EX), 32'd1);
            tick();
            if (i == 14) check("sat_reach_max", 32'(s_ldu_cnt), 32'hF);
        end
        check("sat_hold_max", 32'(s_ldu_cnt), 32'hF);
        check("wide_cnt_16", 32'(ldu_cnt), 32'd16);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
